// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a fixed-latency single-port memory.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie instead of alternating.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

  localparam logic [3:0] LatM1 = 4'(MEM_LAT - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_last;
  logic                r_port;
  logic                r_we;
  logic                r_gnt0, r_gnt1, r_done0, r_done1;
  logic                r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata0, r_rdata1;

  logic                w_any;
  logic                w_win;

  assign w_any = req0 | req1;

`ifdef ARB_FIXED_PRIO_EN
  assign w_win = ~req0;
`else
  // On a tie the port that did not complete last goes next.
  assign w_win = (req0 && req1) ? ~r_last : req1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_port      <= w_win;
            r_we        <= w_win ? we1 : we0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win ? we1 : we0;
            r_mem_addr  <= w_win ? addr1 : addr0;
            r_mem_wdata <= w_win ? wdata1 : wdata0;
            r_gnt0      <= ~w_win;
            r_gnt1      <= w_win;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= LatM1;
          r_state <= StWait;
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            if (r_port) begin
              r_done1 <= 1'b1;
              if (!r_we) r_rdata1 <= mem_rdata;
            end else begin
              r_done0 <= 1'b1;
              if (!r_we) r_rdata0 <= mem_rdata;
            end
            r_last  <= r_port;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign done0     = r_done0;
  assign done1     = r_done1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
